// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for a 4-bit signed calculator: collects operands and
// operators, drives an external adder/subtractor and captures its sum after a settle window.
module calc_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       num_valid,
  input  logic [3:0] num_in,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  output logic       ready,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  output logic       dp_sub,
  input  logic [3:0] dp_sum,
  input  logic       dp_ovf,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HAVE_A = 2'd1;
  localparam logic [1:0] WAIT_B = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_EQ  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [1:0] state_r, state_s;
  logic [3:0] acc_r, acc_s;
  logic [3:0] opb_r, opb_s;
  logic       sub_r, sub_s;
  logic [3:0] cnt_r, cnt_s;
  logic [3:0] result_r, result_s;
  logic       rv_r, rv_s;
  logic       err_r, err_s;
  logic       ready_r, ready_s;
  logic       clr_s;

  assign clr_s = op_valid && (op_code == OP_CLR);

  // Next-state and datapath-register update rules.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    opb_s    = opb_r;
    sub_s    = sub_r;
    cnt_s    = cnt_r;
    result_s = result_r;
    err_s    = err_r;
    rv_s     = 1'b0;
    if (clr_s) begin
      state_s  = IDLE;
      acc_s    = 4'd0;
      opb_s    = 4'd0;
      sub_s    = 1'b0;
      cnt_s    = 4'd0;
      result_s = 4'd0;
      err_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (num_valid) begin
            acc_s   = num_in;
            state_s = HAVE_A;
          end else begin
            state_s = IDLE;
          end
        end
        HAVE_A: begin
          // A number wins over a coincident operator.
          if (num_valid) begin
            acc_s = num_in;
          end else if (op_valid) begin
            case (op_code)
              OP_ADD, OP_SUB: begin
                sub_s   = op_code[0];
                state_s = WAIT_B;
              end
              OP_EQ: begin
                result_s = acc_r;
                rv_s     = 1'b1;
              end
              default: state_s = state_r;
            endcase
          end else begin
            state_s = HAVE_A;
          end
        end
        WAIT_B: begin
          if (num_valid) begin
            opb_s   = num_in;
            cnt_s   = SETTLE_LOAD;
            state_s = EXEC;
          end else if (op_valid && !op_code[1]) begin
            sub_s = op_code[0];
          end else begin
            sub_s = sub_r;
          end
        end
        EXEC: begin
          // Operands stay frozen until the counter has run out, then the sum is taken.
          if (cnt_r != 4'd0) begin
            cnt_s = cnt_r - 4'd1;
          end else begin
            acc_s    = dp_sum;
            result_s = dp_sum;
            err_s    = err_r | dp_ovf;
            rv_s     = 1'b1;
            state_s  = HAVE_A;
          end
        end
        default: state_s = IDLE;
      endcase
    end
    ready_s = (state_s != EXEC);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      acc_r    <= 4'd0;
      opb_r    <= 4'd0;
      sub_r    <= 1'b0;
      cnt_r    <= 4'd0;
      result_r <= 4'd0;
      rv_r     <= 1'b0;
      err_r    <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      opb_r    <= opb_s;
      sub_r    <= sub_s;
      cnt_r    <= cnt_s;
      result_r <= result_s;
      rv_r     <= rv_s;
      err_r    <= err_s;
      ready_r  <= ready_s;
    end
  end

  assign ready        = ready_r;
  assign dp_a         = acc_r;
  assign dp_b         = opb_r;
  assign dp_sub       = sub_r;
  assign result       = result_r;
  assign result_valid = rv_r;
  assign err          = err_r;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: integer-level calculator model checked every
// cycle on the default instance, plus literal checks and settle-latency checks at 0 and 15.
module tb_calc_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       nv, ov;
  logic [3:0] nin;
  logic [1:0] oc;
  logic       ready, dp_sub, dp_ovf, rv, err;
  logic [3:0] dp_a, dp_b, dp_sum, result;

  logic       s_nv, s_ov;
  logic [3:0] s_nin;
  logic [1:0] s_oc;
  logic       rdy0, sub0, ovf0, rv0, err0, rdy15, sub15, ovf15, rv15, err15;
  logic [3:0] a0, b0, sum0, res0, a15, b15, sum15, res15;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // External 4-bit adder/subtractor the controller drives.
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [3:0] r;
    logic o;
    r = s ? (a - b) : (a + b);
    o = s ? ((a[3] != b[3]) && (r[3] != a[3])) : ((a[3] == b[3]) && (r[3] != a[3]));
    return {o, r};
  endfunction

  assign {dp_ovf, dp_sum} = alu(dp_a, dp_b, dp_sub);
  assign {ovf0, sum0}     = alu(a0, b0, sub0);
  assign {ovf15, sum15}   = alu(a15, b15, sub15);

  calc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .num_valid(nv), .num_in(nin), .op_valid(ov), .op_code(oc),
    .ready(ready), .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_sum(dp_sum), .dp_ovf(dp_ovf),
    .result(result), .result_valid(rv), .err(err)
  );

  calc_seq_ctrl #(.SETTLE_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .num_valid(s_nv), .num_in(s_nin), .op_valid(s_ov), .op_code(s_oc),
    .ready(rdy0), .dp_a(a0), .dp_b(b0), .dp_sub(sub0), .dp_sum(sum0), .dp_ovf(ovf0),
    .result(res0), .result_valid(rv0), .err(err0)
  );

  calc_seq_ctrl #(.SETTLE_CYCLES(15)) u15 (
    .clk(clk), .rst_n(rst_n), .num_valid(s_nv), .num_in(s_nin), .op_valid(s_ov), .op_code(s_oc),
    .ready(rdy15), .dp_a(a15), .dp_b(b15), .dp_sub(sub15), .dp_sum(sum15), .dp_ovf(ovf15),
    .result(res15), .result_valid(rv15), .err(err15)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lo4(input int x);
    return x[3:0];
  endfunction

  // Calculator model in plain integers: mode 0 empty, 1 have A, 2 awaiting B, 3 busy.
  int m_mode, m_acc, m_b, m_cyc, m_cap_at, raw;
  bit m_sub, m_err, m_rv;
  logic [3:0] m_res;

  always @(posedge clk) begin
    m_cyc++;
    m_rv = 1'b0;
    if (!rst_n || (ov && oc == 2'b11)) begin
      m_mode = 0; m_acc = 0; m_b = 0; m_sub = 1'b0; m_res = 4'd0; m_err = 1'b0;
    end else if (m_mode == 3) begin
      if (m_cyc == m_cap_at) begin
        raw = m_sub ? (m_acc - m_b) : (m_acc + m_b);
        if (raw > 7 || raw < -8) m_err = 1'b1;
        m_acc = int'($signed(lo4(raw)));
        m_res = lo4(raw);
        m_rv = 1'b1;
        m_mode = 1;
      end
    end else if (nv) begin
      if (m_mode == 2) begin
        m_b = int'($signed(nin));
        m_cap_at = m_cyc + 1 + 1;
        m_mode = 3;
      end else begin
        m_acc = int'($signed(nin));
        m_mode = 1;
      end
    end else if (ov) begin
      if (m_mode == 1 && oc == 2'b10) begin
        m_res = lo4(m_acc);
        m_rv = 1'b1;
      end else if ((m_mode == 1 || m_mode == 2) && oc != 2'b10) begin
        m_sub = (oc == 2'b01);
        m_mode = 2;
      end
    end
  end

  // Cycle-by-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", {3'b000, ready}, {3'b000, m_mode != 3});
      chk("result", result, m_res);
      chk("result_valid", {3'b000, rv}, {3'b000, m_rv});
      chk("err", {3'b000, err}, {3'b000, m_err});
      chk("dp_a", dp_a, lo4(m_acc));
      chk("dp_b", dp_b, lo4(m_b));
      chk("dp_sub", {3'b000, dp_sub}, {3'b000, m_sub});
    end
  end

  task automatic num(input logic [3:0] v);
    nv = 1'b1; nin = v;
    @(posedge clk); @(negedge clk);
    nv = 1'b0;
  endtask

  task automatic op(input logic [1:0] c);
    ov = 1'b1; oc = c;
    @(posedge clk); @(negedge clk);
    ov = 1'b0;
  endtask

  task automatic both(input logic [3:0] v, input logic [1:0] c);
    nv = 1'b1; nin = v; ov = 1'b1; oc = c;
    @(posedge clk); @(negedge clk);
    nv = 1'b0; ov = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic s_step(input logic n, input logic [3:0] v, input logic o, input logic [1:0] c);
    s_nv = n; s_nin = v; s_ov = o; s_oc = c;
    @(posedge clk); @(negedge clk);
    s_nv = 1'b0; s_ov = 1'b0;
  endtask

  int lat0, lat15;

  initial begin
    rst_n = 1'b0; nv = 1'b0; nin = 4'd0; ov = 1'b0; oc = 2'b00;
    s_nv = 1'b0; s_nin = 4'd0; s_ov = 1'b0; s_oc = 2'b00;
    m_cyc = 0; m_cap_at = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {3'b000, ready}, 4'd1);
    chk("rst result", result, 4'd0);
    chk("rst dp_a", dp_a, 4'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 3 + 2, pulse exactly two edges after the operand edge, then equals
    op(2'b00);
    num(4'd3); op(2'b00); num(4'd2);
    chk("add rv e0", {3'b000, rv}, 4'd0);
    idle(1);
    chk("add rv e1", {3'b000, rv}, 4'd0);
    idle(1);
    chk("add rv e2", {3'b000, rv}, 4'd1);
    chk("add result", result, 4'b0101);
    chk("add err", {3'b000, err}, 4'd0);
    op(2'b10);
    chk("eq rv", {3'b000, rv}, 4'd1);
    chk("eq result", result, 4'b0101);

    // overflow: 7 + 1, then keep going with err sticky
    op(2'b11);
    num(4'd7); op(2'b00); num(4'd1); idle(2);
    chk("ovf result", result, 4'b1000);
    chk("ovf err", {3'b000, err}, 4'd1);
    op(2'b00); num(4'd1); idle(2);
    chk("ovf2 result", result, 4'b1001);
    chk("ovf2 err", {3'b000, err}, 4'd1);

    // chaining: 2 - 5 + 1
    op(2'b11);
    num(4'd2); op(2'b01); num(4'd5); idle(2);
    chk("chain1", result, 4'b1101);
    op(2'b00); num(4'd1); idle(2);
    chk("chain2", result, 4'b1110);
    chk("chain err", {3'b000, err}, 4'd0);
    both(4'd5, 2'b00);
    chk("coincide dp_a", dp_a, 4'd5);
    chk("coincide ready", {3'b000, ready}, 4'd1);

    // op replaced in WAIT_B, equals ignored there, strobes in EXEC dropped
    op(2'b11);
    op(2'b00);
    num(4'd4); op(2'b00); op(2'b01); op(2'b10); num(4'd3);
    chk("exec dp_sub", {3'b000, dp_sub}, 4'd1);
    chk("exec ready", {3'b000, ready}, 4'd0);
    both(4'd6, 2'b00);
    op(2'b10);
    chk("repl result", result, 4'd1);
    chk("repl dp_a", dp_a, 4'd1);

    // clear during EXEC with err set
    num(4'd7); op(2'b00); num(4'd1); idle(2);
    op(2'b00); num(4'd3);
    op(2'b11);
    chk("clr ready", {3'b000, ready}, 4'd1);
    chk("clr result", result, 4'd0);
    chk("clr err", {3'b000, err}, 4'd0);
    chk("clr rv", {3'b000, rv}, 4'd0);
    idle(3);

    // reset during EXEC
    num(4'd7); op(2'b00); num(4'd1); idle(2);
    op(2'b00); num(4'd3);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("rst2 ready", {3'b000, ready}, 4'd1);
    chk("rst2 err", {3'b000, err}, 4'd0);
    chk("rst2 dp_b", dp_b, 4'd0);
    idle(3);

    // settle latency at 0 and 15: 3 + 2
    s_step(1'b1, 4'd3, 1'b0, 2'b00);
    s_step(1'b0, 4'd0, 1'b1, 2'b00);
    s_step(1'b1, 4'd2, 1'b0, 2'b00);
    lat0 = -1; lat15 = -1;
    for (int k = 1; k <= 30; k++) begin
      if (rv0 && lat0 < 0) lat0 = k - 1;
      if (rv15 && lat15 < 0) lat15 = k - 1;
      @(posedge clk); @(negedge clk);
    end
    chk("latency0", lo4(lat0), 4'd1);
    chk("latency15", lo4(lat15 > 15 ? lat15 - 16 : lat15 + 100), 4'd0);
    chk("res0", res0, 4'b0101);
    chk("res15", res15, 4'b0101);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
